// File: rtl/pid_sequencer_pkg.sv
// Shared types and constants for the PID sequencer: FSM state, shadow reset
// defaults and the data-width defaults common with the `pid` core.
package pid_pkg;

  localparam int PID_D_WIDTH = 16;
  localparam int PID_Q_BITS  = 13;

  localparam logic [PID_D_WIDTH-1:0] SHADOW0_RST = 16'h0200;
  localparam logic [PID_D_WIDTH-1:0] SHADOW1_RST = 16'h1000;
  localparam logic [PID_D_WIDTH-1:0] CLAMP_RST   = 16'h7FFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_ITER = 2'd3
  } state_t;

  // Reset value of shadow slot idx, or of the clamp limit when is_clamp is set.
  function automatic logic [PID_D_WIDTH-1:0] shadow_rst(input int idx, input bit is_clamp);
    if (is_clamp) return CLAMP_RST;
    case (idx)
      0:       return SHADOW0_RST;
      1:       return SHADOW1_RST;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/pid_sequencer_if.sv
// Core-side bus between the sequencer (master) and the `pid` core (slave).
interface pid_sequencer_if #(
  parameter int D_WIDTH = 16
);
  // No ready back-pressure: the core accepts a register write on every cycle
  // pid_write_enable is low, and presents a result by raising pid_out_valid
  // while pid_iterate_enable is high; only the rising edge of valid is consumed.
  logic               pid_write_enable;
  logic               pid_iterate_enable;
  logic [D_WIDTH-1:0] pid_reg_addr;
  logic [D_WIDTH-1:0] pid_reg_data;
  logic [D_WIDTH-1:0] pid_out;
  logic               pid_out_valid;

  modport master (
    output pid_write_enable, pid_iterate_enable, pid_reg_addr, pid_reg_data,
    input  pid_out, pid_out_valid
  );

  modport slave (
    input  pid_write_enable, pid_iterate_enable, pid_reg_addr, pid_reg_data,
    output pid_out, pid_out_valid
  );
endinterface

// File: rtl/pid_sequencer_iter_timer.sv
// Iteration watchdog: load on iteration start, count down while running,
// o_expire marks the last allowed cycle of a TIMEOUT-cycle window.
module pid_iter_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_run,
  output logic o_expire
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= CNT_W'(TIMEOUT - 1);
    end else if (i_run && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expire = i_run && (r_count == '0);
endmodule

// File: rtl/pid_sequencer.sv
// Control sequencer in front of the `pid` core: shadow gains, LOAD/iterate pacing,
// result capture, sticky overrun/timeout flags. Optional PID_OUT_CLAMP_EN saturates ctrl_out.
module pid_sequencer
  import pid_pkg::*;
#(
  parameter int D_WIDTH = PID_D_WIDTH,
  parameter int Q_BITS  = PID_Q_BITS,
  parameter int N_REGS  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               tick,
  input  logic               cfg_we,
  input  logic [D_WIDTH-1:0] cfg_addr,
  input  logic [D_WIDTH-1:0] cfg_data,
  input  logic               cfg_commit,
  input  logic               err_clr,
  pid_sequencer_if.master    core,
  output logic [D_WIDTH-1:0] ctrl_out,
  output logic               ctrl_out_valid,
  output logic               busy,
  output logic               overrun_err,
  output logic               timeout_err,
  output state_t             o_dbg_state
);
  localparam int IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REGS - 1);

  if (Q_BITS >= D_WIDTH || N_REGS < 1 || TIMEOUT < 1) begin : g_bad_params
    $error("pid_sequencer: need Q_BITS < D_WIDTH, N_REGS >= 1, TIMEOUT >= 1");
  end

  state_t             r_state, w_next;
  logic [IDX_W-1:0]   r_idx;
  logic [D_WIDTH-1:0] r_shadow [N_REGS];
  logic               r_pending, r_enable_d, r_valid_d;
  logic [D_WIDTH-1:0] r_ctrl_out;
  logic               r_ctrl_valid, r_overrun, r_timeout;
  logic [D_WIDTH-1:0] w_result;
  logic               w_enable_rise, w_valid_rise, w_load_last, w_load_start;
  logic               w_busy, w_timer_load, w_expire, w_capture, w_timeout;

  assign w_enable_rise = enable && !r_enable_d;
  assign w_valid_rise  = core.pid_out_valid && !r_valid_d;
  assign w_load_last   = (r_state == ST_LOAD) && (r_idx == LAST_IDX);
  assign w_busy        = (r_state == ST_LOAD) || (r_state == ST_ITER);
  assign w_load_start  = (w_next == ST_LOAD) && (r_state != ST_LOAD);
  assign w_capture     = (r_state == ST_ITER) && w_valid_rise;
  assign w_timeout     = (r_state == ST_ITER) && w_expire && !w_valid_rise;

  always_comb begin
    w_next       = r_state;
    w_timer_load = 1'b0;
    case (r_state)
      ST_IDLE: if (w_enable_rise || (enable && cfg_commit)) w_next = ST_LOAD;
      ST_LOAD: if (w_load_last) w_next = enable ? ST_WAIT : ST_IDLE;
      ST_WAIT: begin
        // A pending reload is always serviced before the next sample tick.
        if (!enable)                       w_next = ST_IDLE;
        else if (r_pending || cfg_commit)  w_next = ST_LOAD;
        else if (tick) begin
          w_next       = ST_ITER;
          w_timer_load = 1'b1;
        end
      end
      ST_ITER: if (w_valid_rise || w_expire) w_next = enable ? ST_WAIT : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  pid_iter_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_timer_load),
    .i_run    (r_state == ST_ITER),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx        <= '0;
      r_pending    <= 1'b0;
      r_enable_d   <= 1'b0;
      r_valid_d    <= 1'b0;
      r_ctrl_out   <= '0;
      r_ctrl_valid <= 1'b0;
      r_overrun    <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_enable_d   <= enable;
      r_valid_d    <= core.pid_out_valid;
      r_ctrl_valid <= w_capture;
      if (r_state == ST_LOAD) r_idx <= w_load_last ? '0 : r_idx + 1'b1;
      if (w_load_start)              r_pending <= 1'b0;
      else if (cfg_commit && w_busy) r_pending <= 1'b1;
      if (w_capture) r_ctrl_out <= w_result;
      if (tick && w_busy) r_overrun <= 1'b1;
      else if (err_clr)   r_overrun <= 1'b0;
      if (w_timeout)      r_timeout <= 1'b1;
      else if (err_clr)   r_timeout <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REGS; i++) r_shadow[i] <= D_WIDTH'(shadow_rst(i, 1'b0));
    end else if (cfg_we && (cfg_addr < D_WIDTH'(N_REGS))) begin
      r_shadow[cfg_addr[IDX_W-1:0]] <= cfg_data;
    end
  end

`ifdef PID_OUT_CLAMP_EN
  logic [D_WIDTH-1:0]        r_clamp;
  logic signed [D_WIDTH-1:0] w_raw, w_lim_pos, w_lim_neg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_clamp <= D_WIDTH'(shadow_rst(0, 1'b1));
    else if (cfg_we && (cfg_addr == D_WIDTH'(N_REGS))) r_clamp <= cfg_data;
  end

  assign w_raw     = signed'(core.pid_out);
  assign w_lim_pos = signed'(r_clamp);
  assign w_lim_neg = -w_lim_pos;
  assign w_result  = (w_raw > w_lim_pos) ? w_lim_pos :
                     (w_raw < w_lim_neg) ? w_lim_neg : w_raw;
`else
  assign w_result = core.pid_out;
`endif

  assign core.pid_write_enable   = (r_state != ST_LOAD);
  assign core.pid_iterate_enable = (r_state == ST_ITER);
  assign core.pid_reg_addr       = (r_state == ST_LOAD) ? D_WIDTH'(r_idx) : '0;
  assign core.pid_reg_data       = (r_state == ST_LOAD) ? r_shadow[r_idx] : '0;

  assign ctrl_out       = r_ctrl_out;
  assign ctrl_out_valid = r_ctrl_valid;
  assign busy           = w_busy;
  assign overrun_err    = r_overrun;
  assign timeout_err    = r_timeout;
  assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_pid_sequencer.sv
// Directed bench for pid_sequencer: load sequencing, iteration pacing, overrun,
// timeout, reload on commit, enable drop, clamp (PID_OUT_CLAMP_EN) and reset mid-LOAD.
module tb_pid_sequencer;
  import pid_pkg::*;

`ifdef PID_OUT_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, enable, tick, cfg_we, cfg_commit, err_clr;
  logic [15:0] cfg_addr, cfg_data, ctrl_out;
  logic        ctrl_out_valid, busy, overrun_err, timeout_err;
  state_t      dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int v0;
  logic [15:0] exp_q[$];
  logic [31:0] wr_log[$];

  pid_sequencer_if #(.D_WIDTH(16)) bus ();

  pid_sequencer #(.D_WIDTH(16), .Q_BITS(13), .N_REGS(4), .TIMEOUT(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .tick           (tick),
    .cfg_we         (cfg_we),
    .cfg_addr       (cfg_addr),
    .cfg_data       (cfg_data),
    .cfg_commit     (cfg_commit),
    .err_clr        (err_clr),
    .core           (bus),
    .ctrl_out       (ctrl_out),
    .ctrl_out_valid (ctrl_out_valid),
    .busy           (busy),
    .overrun_err    (overrun_err),
    .timeout_err    (timeout_err),
    .o_dbg_state    (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every ctrl_out_valid pulse must match the next expected result
  always @(negedge clk) begin
    if (ctrl_out_valid === 1'b1) begin
      n_valid++;
      if (exp_q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
      else                   check("sb_ctrl_out", ctrl_out, exp_q.pop_front());
    end
    if (bus.pid_write_enable === 1'b0) wr_log.push_back({bus.pid_reg_addr, bus.pid_reg_data});
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input state_t s, input int budget, input string tag);
    int n = 0;
    while (dbg_state !== s && n < budget) begin
      cyc();
      n++;
    end
    check(tag, dbg_state, s);
  endtask

  task automatic check_load(input logic [15:0] d1);
    logic [15:0] exp_d [4];
    exp_d[0] = 16'h0200; exp_d[1] = d1; exp_d[2] = 16'h0000; exp_d[3] = 16'h0000;
    check("load_count", wr_log.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < wr_log.size()) begin
        check($sformatf("load_addr%0d", i), wr_log[i][31:16], i);
        check($sformatf("load_data%0d", i), wr_log[i][15:0], exp_d[i]);
      end
    end
  endtask

  task automatic run_iter(input logic [15:0] raw, input logic [15:0] exp, input string tag);
    tick = 1'b1; cyc(); tick = 1'b0;
    cyc();
    bus.pid_out = raw; bus.pid_out_valid = 1'b1; exp_q.push_back(exp);
    cyc();
    check(tag, ctrl_out, exp);
    bus.pid_out_valid = 1'b0;
    cyc();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; tick = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0; err_clr = 1'b0;
    cfg_addr = '0; cfg_data = '0;
    bus.pid_out = '0; bus.pid_out_valid = 1'b0;
    cyc(); cyc();

    // reset state
    check("rst_we_n", bus.pid_write_enable, 1'b1);
    check("rst_iter", bus.pid_iterate_enable, 1'b0);
    check("rst_addr", bus.pid_reg_addr, 16'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_ctrl_out", ctrl_out, 16'h0);
    check("rst_errs", {overrun_err, timeout_err}, 2'b00);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 1'b0; cyc();

    // enable -> 4-cycle load of shadow defaults
    enable = 1'b1; wr_log.delete(); cyc();
    check("load_state", dbg_state, ST_LOAD);
    check("load_we_n", bus.pid_write_enable, 1'b0);
    wait_state(ST_WAIT, 20, "load1_done");
    check_load(16'h1000);
    check("post_load_we_n", bus.pid_write_enable, 1'b1);

    // normal iteration
    tick = 1'b1; cyc(); tick = 1'b0;
    check("iter_state", dbg_state, ST_ITER);
    check("iterate_on", bus.pid_iterate_enable, 1'b1);
    repeat (4) cyc();
    bus.pid_out = 16'h0123; bus.pid_out_valid = 1'b1; exp_q.push_back(16'h0123);
    cyc();
    check("result_valid", ctrl_out_valid, 1'b1);
    check("result_value", ctrl_out, 16'h0123);
    check("iterate_drop", bus.pid_iterate_enable, 1'b0);
    check("back_to_wait", dbg_state, ST_WAIT);
    bus.pid_out_valid = 1'b0; cyc();
    check("valid_one_cycle", ctrl_out_valid, 1'b0);

    // overrun: tick during ITER, set beats err_clr
    v0 = n_valid;
    tick = 1'b1; cyc(); tick = 1'b0;
    tick = 1'b1; cyc(); tick = 1'b0;
    check("overrun_set", overrun_err, 1'b1);
    check("overrun_still_iter", dbg_state, ST_ITER);
    tick = 1'b1; err_clr = 1'b1; cyc(); tick = 1'b0; err_clr = 1'b0;
    check("overrun_set_wins", overrun_err, 1'b1);
    bus.pid_out = 16'h0456; bus.pid_out_valid = 1'b1; exp_q.push_back(16'h0456);
    cyc(); bus.pid_out_valid = 1'b0; cyc();
    check("overrun_one_valid", n_valid - v0, 32'd1);
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    check("overrun_cleared", overrun_err, 1'b0);

    // timeout: core silent for TIMEOUT cycles
    v0 = n_valid;
    tick = 1'b1; cyc(); tick = 1'b0;
    repeat (63) cyc();
    check("timeout_not_yet", timeout_err, 1'b0);
    check("timeout_still_iter", dbg_state, ST_ITER);
    cyc();
    check("timeout_set", timeout_err, 1'b1);
    check("timeout_wait", dbg_state, ST_WAIT);
    check("timeout_iter_drop", bus.pid_iterate_enable, 1'b0);
    check("timeout_ctrl_held", ctrl_out, 16'h0456);
    check("timeout_no_valid", n_valid - v0, 32'd0);
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    check("timeout_cleared", timeout_err, 1'b0);
    run_iter(16'h0789, 16'h0789, "after_timeout_value");
    check("after_timeout_clean", timeout_err, 1'b0);

    // shadow update + commit during ITER -> reload before next iterate
    cfg_we = 1'b1; cfg_addr = 16'd1; cfg_data = 16'h0800; cyc();
    cfg_addr = 16'd7; cfg_data = 16'hBEEF; cyc();
    cfg_we = 1'b0;
    tick = 1'b1; cyc(); tick = 1'b0;
    cfg_commit = 1'b1; cyc(); cfg_commit = 1'b0;
    check("commit_iter_continues", dbg_state, ST_ITER);
    bus.pid_out = 16'h0ABC; bus.pid_out_valid = 1'b1; exp_q.push_back(16'h0ABC);
    wr_log.delete(); cyc(); bus.pid_out_valid = 1'b0;
    check("commit_iter_done", dbg_state, ST_WAIT);
    check("commit_iter_value", ctrl_out, 16'h0ABC);
    cyc();
    check("pending_reload", dbg_state, ST_LOAD);
    tick = 1'b1; cyc(); tick = 1'b0;
    check("overrun_in_load", overrun_err, 1'b1);
    wait_state(ST_WAIT, 20, "reload_done");
    check_load(16'h0800);
    cyc();
    check("load_tick_dropped", dbg_state, ST_WAIT);
    err_clr = 1'b1; cyc(); err_clr = 1'b0;

    // commit in WAIT -> immediate load
    wr_log.delete(); cfg_commit = 1'b1; cyc(); cfg_commit = 1'b0;
    check("commit_wait_load", dbg_state, ST_LOAD);
    wait_state(ST_WAIT, 20, "commit_wait_done");
    check_load(16'h0800);

    // clamp limit (ignored without the clamp)
    cfg_we = 1'b1; cfg_addr = 16'd4; cfg_data = 16'h0100; cyc(); cfg_we = 1'b0;
    run_iter(16'h7000, CLAMP ? 16'h0100 : 16'h7000, "clamp_pos");
    run_iter(16'h9000, CLAMP ? 16'hFF00 : 16'h9000, "clamp_neg");
    run_iter(16'h00FF, 16'h00FF, "clamp_inside");

    // enable drop mid-ITER: iteration completes, then IDLE
    tick = 1'b1; cyc(); tick = 1'b0;
    enable = 1'b0; cyc(); cyc();
    check("drop_enable_iter", dbg_state, ST_ITER);
    bus.pid_out = 16'h0042; bus.pid_out_valid = 1'b1; exp_q.push_back(16'h0042);
    cyc(); bus.pid_out_valid = 1'b0;
    check("drop_enable_idle", dbg_state, ST_IDLE);
    check("drop_enable_value", ctrl_out, 16'h0042);
    check("drop_enable_busy", busy, 1'b0);
    cfg_commit = 1'b1; cyc(); cfg_commit = 1'b0;
    check("idle_commit_no_enable", dbg_state, ST_IDLE);
    check("idle_ctrl_held", ctrl_out, 16'h0042);

    // reset mid-LOAD
    enable = 1'b1; cyc();
    check("mid_load_state", dbg_state, ST_LOAD);
    cyc();
    rst = 1'b1; #1;
    check("rst_mid_we_n", bus.pid_write_enable, 1'b1);
    check("rst_mid_addr", bus.pid_reg_addr, 16'h0);
    check("rst_mid_data", bus.pid_reg_data, 16'h0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_ctrl_out", ctrl_out, 16'h0);
    check("rst_mid_state", dbg_state, ST_IDLE);
    cyc(); wr_log.delete(); rst = 1'b0;
    wait_state(ST_WAIT, 20, "post_rst_load_done");
    check_load(16'h1000);

    check("sb_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
